// File: rtl/custom_pio_responder.sv
// Fabric-side responder for the custom PIO nibble bus: decodes 4-phase req/ack
// transactions into reads/writes of a 16 x 8-bit register file (address 15 = status).
module custom_pio_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire  [7:0] pio_io,
  input  logic [7:0] status_in,
  input  logic [3:0] fab_addr,
  output logic [7:0] fab_rdata,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] err_cnt
);

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NIB_W-1:0]  STATUS_ADDR = 4'hF;
  localparam logic [BYTE_W-1:0] ERR_MAX     = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ACK,
    S_HI_WAIT,
    S_HI_ACK,
    S_LO_WAIT,
    S_LO_ACK
  } state_e;

  // Two-flop synchronisers for the host-driven pins
  logic [1:0]            req_sync_q;
  logic [1:0]            rnw_sync_q;
  logic [1:0][NIB_W-1:0] din_sync_q;
  logic                  req_s;
  logic                  rnw_s;
  logic [NIB_W-1:0]      din_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync_q <= '0;
      rnw_sync_q <= '0;
      din_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[0], pio_io[7]};
      rnw_sync_q <= {rnw_sync_q[0], pio_io[5]};
      din_sync_q <= {din_sync_q[0], pio_io[3:0]};
    end
  end

  assign req_s = req_sync_q[1];
  assign rnw_s = rnw_sync_q[1];
  assign din_s = din_sync_q[1];

  state_e              state_q,     state_d;
  logic                ack_q,       ack_d;
  logic                oe_q,        oe_d;
  logic [NIB_W-1:0]    dout_q,      dout_d;
  logic [NIB_W-1:0]    addr_q,      addr_d;
  logic                rnw_q,       rnw_d;
  logic [NIB_W-1:0]    hi_q,        hi_d;
  logic [BYTE_W-1:0]   rd_byte_q,   rd_byte_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [BYTE_W-1:0]   err_q,       err_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [NIB_W-1:0]    wr_addr_q,   wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q,   wr_data_d;
  logic                reg_we_c;
  logic [BYTE_W-1:0]   regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      addr_q      <= '0;
      rnw_q       <= 1'b0;
      hi_q        <= '0;
      rd_byte_q   <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      hi_q        <= hi_d;
      rd_byte_q   <= rd_byte_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Handshake sequencer; the watchdog abort overrides any pending transition
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
    hi_d        = hi_q;
    rd_byte_d   = rd_byte_q;
    err_d       = err_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we_c    = 1'b0;
    cnt_d       = '0;

    if ((state_q != S_IDLE) && (cnt_q == CNT_LAST)) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
      oe_d    = 1'b0;
      if (err_q != ERR_MAX) begin
        err_d = err_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_s) begin
            addr_d    = din_s;
            rnw_d     = rnw_s;
            // Snapshot now so both read nibbles come from one coherent byte
            rd_byte_d = (din_s == STATUS_ADDR) ? status_in : regs_q[din_s];
            ack_d     = 1'b1;
            state_d   = S_CMD_ACK;
          end
        end
        S_CMD_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = S_HI_WAIT;
          end
        end
        S_HI_WAIT: begin
          if (req_s) begin
            ack_d = 1'b1;
            if (rnw_q) begin
              dout_d = rd_byte_q[7:4];
              oe_d   = 1'b1;
            end else begin
              hi_d = din_s;
            end
            state_d = S_HI_ACK;
          end
        end
        S_HI_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            state_d = S_LO_WAIT;
          end
        end
        S_LO_WAIT: begin
          if (req_s) begin
            ack_d = 1'b1;
            if (rnw_q) begin
              dout_d = rd_byte_q[3:0];
              oe_d   = 1'b1;
            end else if (addr_q != STATUS_ADDR) begin
              reg_we_c    = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = {hi_q, din_s};
            end
            state_d = S_LO_ACK;
          end
        end
        S_LO_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          oe_d    = 1'b0;
        end
      endcase

      if ((state_d == state_q) && (state_q != S_IDLE)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Register file; entry 15 is never written and is shadowed by status_in on reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we_c) begin
      regs_q[addr_q] <= wr_data_d;
    end
  end

  assign pio_io[6]   = ack_q;
  assign pio_io[3:0] = oe_q ? dout_q : 4'bzzzz;

  assign fab_rdata = (fab_addr == STATUS_ADDR) ? status_in : regs_q[fab_addr];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_cnt   = err_q;

endmodule
